// File: rtl/ifconv_sched.sv
// Round-robin front end that shares one two-stage ifconv converter among NREQ issue ports.
// It carries tag/port/error alongside the converter pipeline and freezes both on downstream backpressure.
module ifconv_sched #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_vld,
  input  logic [65*NREQ-1:0]      req_A,
  input  logic [NREQ-1:0]         req_isS,
  input  logic [2*NREQ-1:0]       req_typ,
  input  logic [TAG_W*NREQ-1:0]   req_tag,
  output logic [NREQ-1:0]         req_gnt,
  input  logic                    flush,
  output logic [64:0]             cv_A,
  output logic                    cv_isS,
  output logic                    cv_toSNG,
  output logic                    cv_toDBL,
  output logic                    cv_toEXT,
  output logic                    cv_en,
  output logic                    cv_clkEn,
  input  logic [81:0]             cv_res,
  input  logic [1:0]              cv_rtyp,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [81:0]             out_res,
  output logic [1:0]              out_rtyp,
  output logic [TAG_W-1:0]        out_tag,
  output logic [1:0]              out_port,
  output logic                    out_err,
  output logic [15:0]             stall_cnt
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]       rr_ptr;
  logic [1:0]       sel;
  logic [1:0]       nxt_ptr;
  logic             found;
  logic             issue;
  int               idx;
  logic [3:0]       vld4;
  logic [3:0]       gnt4;
  logic [1:0]       typ_g;
  logic [64:0]      a_arr   [4];
  logic             iss_arr [4];
  logic [1:0]       typ_arr [4];
  logic [TAG_W-1:0] tag_arr [4];

  logic             vld_p1, vld_p2;
  logic             err_p1, err_p2;
  logic [TAG_W-1:0] tag_p1, tag_p2;
  logic [1:0]       port_p1, port_p2;

  // Stage 0: unpack ports, round-robin search from rr_ptr, drive the converter
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_arr[i]   = '0;
      iss_arr[i] = 1'b0;
      typ_arr[i] = '0;
      tag_arr[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i]   = req_A[65*i +: 65];
      iss_arr[i] = req_isS[i];
      typ_arr[i] = req_typ[2*i +: 2];
      tag_arr[i] = req_tag[TAG_W*i +: TAG_W];
    end
  end

  assign vld4 = 4'(req_vld);

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int j = 0; j < NREQ; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && vld4[idx[1:0]]) begin
        found = 1'b1;
        sel   = idx[1:0];
      end
    end
  end

  assign cv_clkEn = !(vld_p2 && !out_rdy);
  assign issue    = cv_clkEn && !flush && !rst && (|req_vld);
  assign typ_g    = typ_arr[sel];
  assign gnt4     = issue ? (4'b0001 << sel) : 4'b0000;
  assign req_gnt  = gnt4[NREQ-1:0];
  assign nxt_ptr  = (sel == 2'(NREQ-1)) ? 2'd0 : sel + 2'd1;

  assign cv_A     = issue ? a_arr[sel] : '0;
  assign cv_isS   = issue && iss_arr[sel];
  assign cv_toSNG = issue && (typ_g == 2'b01);
  assign cv_toDBL = issue && (typ_g == 2'b10);
  assign cv_toEXT = issue && (typ_g == 2'b11);
  assign cv_en    = issue && (typ_g != 2'b00);

  // Stage 1/2 control: valids, error flags, pointer and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      err_p1    <= 1'b0;
      err_p2    <= 1'b0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      if (cv_clkEn) begin
        vld_p1 <= issue;
        err_p1 <= issue && (typ_g == 2'b00);
        vld_p2 <= vld_p1;
        err_p2 <= err_p1;
      end
      // flush kills both stages even while the converter is frozen
      if (flush) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end
      if (issue) rr_ptr <= nxt_ptr;
      if (vld_p2 && !out_rdy) stall_cnt <= sat_inc16(stall_cnt);
    end
  end

  // Stage 1/2 data: tag and port ride alongside the converter, qualified by the valids
  always_ff @(posedge clk) begin
    if (cv_clkEn) begin
      tag_p1  <= tag_arr[sel];
      port_p1 <= sel;
      tag_p2  <= tag_p1;
      port_p2 <= port_p1;
    end
  end

  // Output: result comes straight from the converter's second stage
  assign out_vld  = vld_p2;
  assign out_tag  = tag_p2;
  assign out_port = port_p2;
  assign out_err  = err_p2;
  assign out_res  = err_p2 ? '0 : cv_res;
  assign out_rtyp = err_p2 ? 2'b00 : cv_rtyp;

endmodule

// File: tb/tb_ifconv_sched.sv
// Bench for ifconv_sched: stand-in two-stage converter plus a queue-based model of in-flight ops.
module tb_ifconv_sched;
  localparam int NREQ  = 2;
  localparam int TAG_W = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_vld;
  logic [129:0] req_A;
  logic [1:0]   req_isS;
  logic [3:0]   req_typ;
  logic [17:0]  req_tag;
  logic [1:0]   req_gnt;
  logic         flush;
  logic [64:0]  cv_A;
  logic         cv_isS, cv_toSNG, cv_toDBL, cv_toEXT, cv_en, cv_clkEn;
  logic [81:0]  cv_res;
  logic [1:0]   cv_rtyp;
  logic         out_vld, out_rdy, out_err;
  logic [81:0]  out_res;
  logic [1:0]   out_rtyp;
  logic [8:0]   out_tag;
  logic [1:0]   out_port;
  logic [15:0]  stall_cnt;

  ifconv_sched #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_A(req_A), .req_isS(req_isS),
    .req_typ(req_typ), .req_tag(req_tag), .req_gnt(req_gnt), .flush(flush),
    .cv_A(cv_A), .cv_isS(cv_isS), .cv_toSNG(cv_toSNG), .cv_toDBL(cv_toDBL),
    .cv_toEXT(cv_toEXT), .cv_en(cv_en), .cv_clkEn(cv_clkEn), .cv_res(cv_res),
    .cv_rtyp(cv_rtyp), .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res),
    .out_rtyp(out_rtyp), .out_tag(out_tag), .out_port(out_port), .out_err(out_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [81:0] conv_res(input logic [64:0] a, input logic s);
    return {s, a[15:0] ^ 16'hA5A5, a};
  endfunction

  // stand-in converter: two registers advancing on clkEn
  logic [81:0] c1_res, c2_res;
  logic [1:0]  c1_rtyp, c2_rtyp;
  always_ff @(posedge clk) begin
    if (cv_clkEn) begin
      c1_res  <= conv_res(cv_A, cv_isS);
      c1_rtyp <= {cv_toDBL | cv_toEXT, cv_toSNG | cv_toEXT};
      c2_res  <= c1_res;
      c2_rtyp <= c1_rtyp;
    end
  end
  assign cv_res  = c2_res;
  assign cv_rtyp = c2_rtyp;

  typedef struct {
    logic [81:0] res;
    logic [1:0]  rtyp;
    logic [8:0]  tag;
    logic [1:0]  port;
    logic        err;
    int          steps;
  } ent_t;

  ent_t q[$];
  int   mrr, mstall;
  int   exp_k;
  logic exp_vld, exp_clken, exp_issue;
  logic [1:0] exp_gnt;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic predict();
    exp_vld   = (q.size() > 0) && (q[0].steps == 0);
    exp_clken = !(exp_vld && !out_rdy);
    exp_k     = -1;
    for (int j = 0; j < NREQ; j++)
      if (exp_k < 0 && req_vld[(mrr + j) % NREQ]) exp_k = (mrr + j) % NREQ;
    exp_issue = exp_clken && !flush && !rst && (exp_k >= 0);
    exp_gnt   = exp_issue ? 2'(1 << exp_k) : 2'b00;
  endtask

  task automatic model_update();
    ent_t e;
    logic [1:0] t;
    if (rst) begin
      q.delete();
      mrr = 0;
      mstall = 0;
      return;
    end
    if (exp_vld && !out_rdy && mstall < 65535) mstall++;
    if (flush) q.delete();
    else if (exp_clken) begin
      if (exp_vld) void'(q.pop_front());
      foreach (q[i]) if (q[i].steps > 0) q[i].steps--;
      if (exp_issue) begin
        t       = req_typ[2*exp_k +: 2];
        e.err   = (t == 2'b00);
        e.res   = e.err ? '0 : conv_res(req_A[65*exp_k +: 65], req_isS[exp_k]);
        e.rtyp  = e.err ? 2'b00 : t;
        e.tag   = req_tag[9*exp_k +: 9];
        e.port  = 2'(exp_k);
        e.steps = 1;
        q.push_back(e);
      end
    end
    if (exp_issue) mrr = (exp_k + 1) % NREQ;
  endtask

  task automatic settle();
    predict();
    @(negedge clk);
  endtask

  task automatic advance();
    predict();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    req_vld = '0; flush = 1'b0; out_rdy = 1'b1; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    advance();
    advance();
    rst = 1'b0;
  endtask

  task automatic set_port(input int p, input logic v, input logic [64:0] a, input logic s,
                          input logic [1:0] t, input logic [8:0] g);
    req_vld[p] = v; req_A[65*p +: 65] = a; req_isS[p] = s;
    req_typ[2*p +: 2] = t; req_tag[9*p +: 9] = g;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
    n_tests++; if (req_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", req_gnt); end
    n_tests++; if (cv_en !== 1'b0) begin n_fail++; $display("FAIL reset_cv_en got=%b exp=0", cv_en); end
    n_tests++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    advance();
  endtask

  task automatic test_single();
    idle();
    set_port(0, 1'b1, 65'd5, 1'b0, 2'b10, 9'h11);
    settle();
    n_tests++; if (req_gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt got=%b exp=01", req_gnt); end
    n_tests++; if ({cv_en, cv_toDBL, cv_A} !== {1'b1, 1'b1, 65'd5}) begin n_fail++; $display("FAIL single_drive got en=%b dbl=%b A=%0h exp 1 1 5", cv_en, cv_toDBL, cv_A); end
    advance();
    idle();
    settle();
    n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_early_vld got=%b exp=0", out_vld); end
    advance();
    settle();
    n_tests++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld got=%b exp=1", out_vld); end
    n_tests++; if ({out_rtyp, out_tag, out_port} !== {2'b10, 9'h11, 2'd0}) begin n_fail++; $display("FAIL single_fields got rtyp=%b tag=%h port=%0d exp 10 011 0", out_rtyp, out_tag, out_port); end
    n_tests++; if (out_res !== conv_res(65'd5, 1'b0)) begin n_fail++; $display("FAIL single_res got=%h exp=%h", out_res, conv_res(65'd5, 1'b0)); end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [8:0] et;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) begin
        set_port(0, 1'b1, 65'(i * 3 + 1), 1'b1, 2'b11, 9'(9'h40 + i));
        set_port(1, 1'b1, 65'(i * 7 + 2), 1'b0, 2'b01, 9'(9'h80 + i));
      end
      settle();
      if (i < 4) begin
        n_tests++; if (req_gnt !== ((i % 2) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_gnt cyc=%0d got=%b", i, req_gnt); end
      end
      if (i >= 2) begin
        et = ((i - 2) % 2) ? 9'(9'h80 + i - 2) : 9'(9'h40 + i - 2);
        n_tests++; if ({out_vld, out_tag, out_port} !== {1'b1, et, 2'((i - 2) % 2)}) begin n_fail++; $display("FAIL b2b_out cyc=%0d got vld=%b tag=%h port=%0d exp tag=%h", i, out_vld, out_tag, out_port, et); end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [81:0] held;
    do_reset();
    idle();
    set_port(0, 1'b1, 65'h1234, 1'b0, 2'b01, 9'h33);
    set_port(1, 1'b1, 65'h5678, 1'b1, 2'b10, 9'h44);
    settle();
    n_tests++; if (req_gnt !== 2'b01) begin n_fail++; $display("FAIL stall_gnt0 got=%b exp=01", req_gnt); end
    advance();
    settle();
    n_tests++; if (req_gnt !== 2'b10) begin n_fail++; $display("FAIL stall_gnt1 got=%b exp=10", req_gnt); end
    advance();
    out_rdy = 1'b0;
    held = conv_res(65'h1234, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_tests++; if ({req_gnt, cv_clkEn} !== 3'b000) begin n_fail++; $display("FAIL stall_freeze cyc=%0d got gnt=%b clkEn=%b exp 00 0", i, req_gnt, cv_clkEn); end
      n_tests++; if ({out_vld, out_tag, out_res} !== {1'b1, 9'h33, held}) begin n_fail++; $display("FAIL stall_hold cyc=%0d got vld=%b tag=%h res=%h", i, out_vld, out_tag, out_res); end
      advance();
    end
    idle();
    settle();
    n_tests++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
    n_tests++; if ({out_vld, out_tag} !== {1'b1, 9'h33}) begin n_fail++; $display("FAIL stall_release got vld=%b tag=%h exp 1 033", out_vld, out_tag); end
    advance();
    settle();
    n_tests++; if ({out_vld, out_tag, out_port} !== {1'b1, 9'h44, 2'd1}) begin n_fail++; $display("FAIL stall_nobubble got vld=%b tag=%h port=%0d exp 1 044 1", out_vld, out_tag, out_port); end
    advance();
  endtask

  task automatic test_illegal();
    do_reset();
    idle();
    set_port(1, 1'b1, 65'h1_2345, 1'b1, 2'b00, 9'h55);
    settle();
    n_tests++; if (req_gnt !== 2'b10) begin n_fail++; $display("FAIL illegal_gnt got=%b exp=10", req_gnt); end
    n_tests++; if ({cv_en, cv_toSNG, cv_toDBL, cv_toEXT} !== 4'b0000) begin n_fail++; $display("FAIL illegal_drive got=%b exp=0000", {cv_en, cv_toSNG, cv_toDBL, cv_toEXT}); end
    advance();
    idle();
    advance();
    settle();
    n_tests++; if ({out_vld, out_err, out_port} !== {1'b1, 1'b1, 2'd1}) begin n_fail++; $display("FAIL illegal_out got vld=%b err=%b port=%0d exp 1 1 1", out_vld, out_err, out_port); end
    n_tests++; if ({out_res, out_rtyp} !== 84'd0) begin n_fail++; $display("FAIL illegal_res got res=%h rtyp=%b exp 0", out_res, out_rtyp); end
    advance();
  endtask

  task automatic test_flush();
    do_reset();
    idle();
    set_port(0, 1'b1, 65'h77, 1'b0, 2'b10, 9'h61);
    set_port(1, 1'b1, 65'h88, 1'b0, 2'b11, 9'h62);
    advance();
    advance();
    flush = 1'b1;
    out_rdy = 1'b0;
    settle();
    n_tests++; if (req_gnt !== 2'b00) begin n_fail++; $display("FAIL flush_gnt got=%b exp=00", req_gnt); end
    advance();
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL flush_vld cyc=%0d got=%b exp=0", i, out_vld); end
      advance();
    end
    settle();
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_stall_cnt got=%0d exp=1", stall_cnt); end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle();
    set_port(0, 1'b1, 65'h9, 1'b0, 2'b01, 9'h70);
    advance();
    advance();
    idle();
    out_rdy = 1'b0;
    advance();
    rst = 1'b1;
    settle();
    n_tests++; if ({out_vld, stall_cnt} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL rstmid_pre got vld=%b stall=%0d exp 1 1", out_vld, stall_cnt); end
    advance();
    idle();
    set_port(0, 1'b1, 65'hA, 1'b0, 2'b10, 9'h71);
    set_port(1, 1'b1, 65'hB, 1'b0, 2'b10, 9'h72);
    settle();
    n_tests++; if ({out_vld, stall_cnt} !== {1'b0, 16'd0}) begin n_fail++; $display("FAIL rstmid_clear got vld=%b stall=%0d exp 0 0", out_vld, stall_cnt); end
    n_tests++; if (req_gnt !== 2'b01) begin n_fail++; $display("FAIL rstmid_gnt got=%b exp=01", req_gnt); end
    advance();
    idle();
    settle();
    n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop got=%b exp=0", out_vld); end
    advance();
    settle();
    n_tests++; if ({out_vld, out_tag} !== {1'b1, 9'h71}) begin n_fail++; $display("FAIL rstmid_new got vld=%b tag=%h exp 1 071", out_vld, out_tag); end
    advance();
  endtask

  task automatic test_random();
    logic [1:0] tk;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int p = 0; p < NREQ; p++)
        set_port(p, 1'($urandom_range(0, 1)), {1'($urandom), $urandom, $urandom}, 1'($urandom),
                 2'($urandom_range(0, 3)), 9'($urandom));
      out_rdy = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 39) == 0);
      settle();
      tk = (exp_k >= 0) ? req_typ[2*exp_k +: 2] : 2'b00;
      n_tests++; if (req_gnt !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, req_gnt, exp_gnt); end
      n_tests++; if (cv_clkEn !== exp_clken) begin n_fail++; $display("FAIL rnd_clken cyc=%0d got=%b exp=%b", c, cv_clkEn, exp_clken); end
      n_tests++; if (cv_en !== (exp_issue && tk != 2'b00)) begin n_fail++; $display("FAIL rnd_cv_en cyc=%0d got=%b exp=%b", c, cv_en, exp_issue && tk != 2'b00); end
      n_tests++; if (out_vld !== exp_vld) begin n_fail++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", c, out_vld, exp_vld); end
      n_tests++; if (stall_cnt !== 16'(mstall)) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", c, stall_cnt, mstall); end
      if (exp_vld) begin
        n_tests++;
        if ({out_res, out_rtyp, out_tag, out_port, out_err} !== {q[0].res, q[0].rtyp, q[0].tag, q[0].port, q[0].err}) begin
          n_fail++;
          $display("FAIL rnd_result cyc=%0d got res=%h rtyp=%b tag=%h port=%0d err=%b exp res=%h rtyp=%b tag=%h port=%0d err=%b",
                   c, out_res, out_rtyp, out_tag, out_port, out_err, q[0].res, q[0].rtyp, q[0].tag, q[0].port, q[0].err);
        end
      end
      advance();
    end
  endtask

  initial begin
    req_A = '0; req_isS = '0; req_typ = '0; req_tag = '0;
    idle();
    mrr = 0; mstall = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
